// File: rtl/tdm_demux_four_one_pkg.sv
// Shared TDM definitions: slot geometry, framing state encodings and the
// per-word action record decoded by the receive-side framer.
package tdm_pkg;

    // Number of time slots per frame and width of the slot index.
    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;

    // Framing state encodings, kept as plain constants so the mux side and
    // older code can compare against them directly.
    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // What the framer does with the word presented this cycle.
    typedef struct packed {
        logic start;    // word becomes slot 0 of a new frame
        logic store;    // word goes into the shadow for the current slot (1..2)
        logic deliver;  // word is slot 3: publish the whole frame
        logic err;      // framing violation seen on this word
        logic to_hunt;  // drop lock and start searching for sync again
    } frame_act_t;

    // True when the slot index points at the final slot of a frame.
    function automatic logic is_last_slot(input logic [SLOT_W-1:0] slot);
        return slot == SLOT_W'(NUM_SLOTS - 1);
    endfunction

endpackage : tdm_pkg

// File: rtl/tdm_demux_four_one_slot_ctr.sv
// Slot position counter for the TDM framer. Loading jumps straight to slot 1
// because the word that triggers a load is itself slot 0.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,       // force back to slot 0
    input  logic              load_one,  // slot 0 consumed, next word is slot 1
    input  logic              en,        // advance by one, wrapping 3 -> 0
    output logic [SLOT_W-1:0] slot,
    output logic              last       // currently at the final slot
);

    logic [SLOT_W-1:0] slot_reg;
    logic [SLOT_W-1:0] slot_next;

    // Next-slot selection: clear beats load, load beats advance.
    always_comb begin
        slot_next = slot_reg;
        if (clr) begin
            slot_next = '0;
        end else if (load_one) begin
            slot_next = SLOT_W'(1);
        end else if (en) begin
            slot_next = slot_reg + SLOT_W'(1);
        end
    end

    // Slot register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_reg <= '0;
        end else begin
            slot_reg <= slot_next;
        end
    end

    assign slot = slot_reg;
    assign last = is_last_slot(slot_reg);

endmodule : tdm_slot_ctr

// File: rtl/tdm_demux_four_one.sv
// Receive end of the 4-channel TDM link. Words for slots 0..2 are held in
// shadow registers; the slot-3 word completes the frame and all four channel
// outputs update together with a one-cycle frame_valid pulse. Framing errors
// drop the partial frame and raise a one-cycle sync_err pulse.
module tdm_demux_four_one
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             din_sync,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err
);

    logic [0:0]        state_reg;
    logic [0:0]        state_next;
    frame_act_t        act;
    logic [SLOT_W-1:0] slot;
    logic              slot_last;

    // Shadow words for slots 0..NUM_SLOTS-2; the last slot bypasses straight
    // to the outputs so it needs no storage.
    logic [WIDTH-1:0]  shadow [0:NUM_SLOTS-2];

    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [WIDTH-1:0]  c_reg;
    logic [WIDTH-1:0]  d_reg;
    logic              frame_valid_reg;
    logic              sync_err_reg;

    // Framing decision for the current word. Nothing happens without
    // din_valid, which also makes both pulses fall on idle cycles.
    always_comb begin
        act        = '0;
        state_next = state_reg;
        if (din_valid) begin
            if (state_reg == ST_HUNT) begin
                // Searching: only a sync word is useful, everything else is dropped quietly.
                if (din_sync) begin
                    act.start  = 1'b1;
                    state_next = ST_LOCKED;
                end
            end else if (din_sync) begin
                // Sync always restarts the frame; it is only an error if it
                // arrives before the previous frame was complete.
                act.start = 1'b1;
                act.err   = (slot != '0);
            end else if (slot == '0) begin
                // Expected a frame start but got payload: lock is lost.
                act.err     = 1'b1;
                act.to_hunt = 1'b1;
                state_next  = ST_HUNT;
            end else if (slot_last) begin
                act.deliver = 1'b1;
            end else begin
                act.store = 1'b1;
            end
        end
    end

    // Framing state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_HUNT;
        end else begin
            state_reg <= state_next;
        end
    end

    tdm_slot_ctr u_slot_ctr (
        .clk      (clk),
        .rst      (rst),
        .clr      (act.to_hunt),
        .load_one (act.start),
        .en       (act.store | act.deliver),
        .slot     (slot),
        .last     (slot_last)
    );

    // One shadow register per non-final slot. Slot 0 is written by a frame
    // start; the middle slots are written when the counter points at them.
    generate
        for (genvar gi = 0; gi < NUM_SLOTS - 1; gi++) begin : g_shadow
            logic [WIDTH-1:0] word_reg;
            logic             wr_en;

            if (gi == 0) begin : g_first
                assign wr_en = act.start;
            end else begin : g_mid
                assign wr_en = act.store && (slot == SLOT_W'(gi));
            end

            // Capture the word for this slot; reset clears stale partial data.
            always_ff @(posedge clk) begin
                if (rst) begin
                    word_reg <= '0;
                end else if (wr_en) begin
                    word_reg <= din;
                end
            end

            assign shadow[gi] = word_reg;
        end
    endgenerate

    // Channel outputs update only when a complete frame is delivered, and
    // hold their last frame through errors and HUNT.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            c_reg <= '0;
            d_reg <= '0;
        end else if (act.deliver) begin
            a_reg <= shadow[0];
            b_reg <= shadow[1];
            c_reg <= shadow[2];
            d_reg <= din;
        end
    end

    // Single-cycle status pulses; deliver and err are mutually exclusive by decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_valid_reg <= 1'b0;
            sync_err_reg    <= 1'b0;
        end else begin
            frame_valid_reg <= act.deliver;
            sync_err_reg    <= act.err;
        end
    end

    assign a           = a_reg;
    assign b           = b_reg;
    assign c           = c_reg;
    assign d           = d_reg;
    assign frame_valid = frame_valid_reg;
    assign sync_err    = sync_err_reg;
    assign locked      = (state_reg == ST_LOCKED);

endmodule : tdm_demux_four_one

// File: tb/tb_tdm_demux_four_one.sv
// Directed and randomized checks of the TDM demultiplexer against a
// frame-level reference model built from a word queue and a lock flag.
module tb_tdm_demux_four_one;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             din_valid = 1'b0;
    logic             din_sync = 1'b0;
    logic [WIDTH-1:0] a, b, c, d;
    logic             frame_valid, locked, sync_err;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit               m_locked;
    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] m_out[4];
    logic             exp_fv;
    logic             exp_err;

    tdm_demux_four_one #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .din_sync    (din_sync),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_q.delete();
        for (int i = 0; i < 4; i++) m_out[i] = '0;
        exp_fv  = 1'b0;
        exp_err = 1'b0;
    endtask

    // Frame-level rules: a frame is four consecutive valid words starting
    // with a sync word; anything else while locked is a framing error.
    task automatic model_word(input logic s, input logic [WIDTH-1:0] w);
        exp_fv  = 1'b0;
        exp_err = 1'b0;
        if (!m_locked) begin
            if (s) begin
                m_locked = 1'b1;
                m_q.delete();
                m_q.push_back(w);
            end
        end else if (s) begin
            if (m_q.size() != 0) exp_err = 1'b1;
            m_q.delete();
            m_q.push_back(w);
        end else if (m_q.size() == 0) begin
            exp_err  = 1'b1;
            m_locked = 1'b0;
        end else begin
            m_q.push_back(w);
            if (m_q.size() == 4) begin
                for (int i = 0; i < 4; i++) m_out[i] = m_q[i];
                m_q.delete();
                exp_fv = 1'b1;
                $display("frame a=%h b=%h c=%h d=%h", m_out[0], m_out[1], m_out[2], m_out[3]);
            end
        end
    endtask

    task automatic check_all();
        chk("a", 32'(a), 32'(m_out[0]));
        chk("b", 32'(b), 32'(m_out[1]));
        chk("c", 32'(c), 32'(m_out[2]));
        chk("d", 32'(d), 32'(m_out[3]));
        chk("frame_valid", 32'(frame_valid), 32'(exp_fv));
        chk("sync_err", 32'(sync_err), 32'(exp_err));
        chk("locked", 32'(locked), 32'(m_locked));
    endtask

    // One clock of stimulus, then compare after the edge.
    task automatic step(input logic v, input logic s, input logic [WIDTH-1:0] w);
        din_valid = v;
        din_sync  = s;
        din       = w;
        @(posedge clk);
        #1;
        if (v) begin
            model_word(s, w);
        end else begin
            exp_fv  = 1'b0;
            exp_err = 1'b0;
        end
        check_all();
        din_valid = 1'b0;
        din_sync  = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst       = 1'b1;
        din_valid = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            model_reset();
            check_all();
        end
        rst = 1'b0;
    endtask

    initial begin
        logic v, s;
        logic [WIDTH-1:0] w;
        model_reset();

        // Reset then idle: everything stays cleared
        do_reset(2);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);

        // Back-to-back frame
        step(1'b1, 1'b1, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        step(1'b1, 1'b0, 8'h33);
        step(1'b1, 1'b0, 8'h44);
        step(1'b0, 1'b0, '0);

        // Same frame with idle gaps between words
        step(1'b1, 1'b1, 8'h11); step(1'b0, 1'b0, 8'hEE);
        step(1'b1, 1'b0, 8'h22); step(1'b0, 1'b0, 8'hEE); step(1'b0, 1'b0, 8'hEE);
        step(1'b1, 1'b0, 8'h33); step(1'b0, 1'b0, 8'hEE);
        step(1'b1, 1'b0, 8'h44); step(1'b0, 1'b0, '0);

        // Premature sync on slot 2
        step(1'b1, 1'b1, 8'h55);
        step(1'b1, 1'b0, 8'h66);
        step(1'b1, 1'b1, 8'h77);
        step(1'b1, 1'b0, 8'h88);
        step(1'b1, 1'b0, 8'h99);
        step(1'b1, 1'b0, 8'hAA);
        step(1'b0, 1'b0, '0);

        // Missing sync at slot 0: lose lock, ignore payload, relock on sync
        step(1'b1, 1'b0, 8'h5A);
        step(1'b1, 1'b0, 8'h12);
        step(1'b1, 1'b0, 8'h34);
        step(1'b1, 1'b1, 8'hC1);
        step(1'b1, 1'b0, 8'hC2);
        step(1'b1, 1'b0, 8'hC3);
        step(1'b1, 1'b0, 8'hC4);

        // Reset in mid-frame, then a fresh frame must not see stale shadows
        step(1'b1, 1'b1, 8'hD1);
        step(1'b1, 1'b0, 8'hD2);
        step(1'b1, 1'b0, 8'hD3);
        do_reset(1);
        step(1'b1, 1'b1, 8'hE1);
        step(1'b1, 1'b0, 8'hE2);
        step(1'b1, 1'b0, 8'hE3);
        step(1'b1, 1'b0, 8'hE4);

        // Randomized traffic: sync mostly where a frame should start
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset(1);
            end else begin
                v = ($urandom_range(0, 3) != 0);
                if (m_locked && m_q.size() == 0)
                    s = ($urandom_range(0, 9) != 0);
                else if (m_locked)
                    s = ($urandom_range(0, 19) == 0);
                else
                    s = ($urandom_range(0, 2) == 0);
                w = WIDTH'($urandom);
                step(v, s, w);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Backstop so the run always ends on its own
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule : tb_tdm_demux_four_one
